// File: rtl/kd_result_serializer.sv
// kd_result_serializer
//   Captures the final per-patch {index, distance} minima of a query into a
//   two-slot ping-pong buffer and drains them one patch per beat over a
//   valid/ready stream, tagging each beat with {query_addr, beat}. Capture of
//   the next query may overlap the draining of the current one.
//
// Optional feature (macro RESULT_THRESH_EN):
//   Adds input dist_thresh. A beat whose distance is above the threshold
//   (unsigned) presents an all-ones index as a no-match marker; the distance
//   itself is passed unchanged.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      upstream valid
//   in_last       upstream query-last; capture strobe = in_valid & in_last
//   in_idx        NUM_PATCH*IDX_W flat indices, patch k at [k*IDX_W +: IDX_W]
//   in_dist       NUM_PATCH*DIST_W flat distances, same packing
//   clear_addr    frame start: zero query address and overflow flag
//   dist_thresh   (RESULT_THRESH_EN only) no-match distance threshold
//   out_valid     result beat available
//   out_ready     downstream accepts beat
//   out_idx       index of current beat
//   out_dist      distance of current beat
//   out_addr      {query_addr, beat}
//   busy          at least one slot holds undrained results
//   overflow      sticky: a capture arrived with both slots full and was dropped
module kd_result_serializer #(
  parameter int NUM_PATCH = 8,
  parameter int IDX_W     = 15,
  parameter int DIST_W    = 11,
  parameter int ADDR_W    = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  input  logic [NUM_PATCH*IDX_W-1:0]            in_idx,
  input  logic [NUM_PATCH*DIST_W-1:0]           in_dist,
  input  logic                                  clear_addr,
`ifdef RESULT_THRESH_EN
  input  logic [DIST_W-1:0]                     dist_thresh,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [IDX_W-1:0]                      out_idx,
  output logic [DIST_W-1:0]                     out_dist,
  output logic [ADDR_W+$clog2(NUM_PATCH)-1:0]   out_addr,
  output logic                                  busy,
  output logic                                  overflow
);

  localparam int BEAT_W = $clog2(NUM_PATCH);

  // Slot storage: [slot][patch]
  logic [IDX_W-1:0]  idx_q  [2][NUM_PATCH];
  logic [DIST_W-1:0] dist_q [2][NUM_PATCH];

  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] query_addr_q, query_addr_d;
  logic              overflow_q, overflow_d;

  logic strobe, xfer, release_beat, cap_accept, cap_drop;
  logic [IDX_W-1:0]  rd_idx;
  logic [DIST_W-1:0] rd_dist;

  assign strobe       = in_valid & in_last;
  assign xfer         = out_valid & out_ready;
  assign release_beat = xfer & (beat_q == BEAT_W'(NUM_PATCH - 1));
  // A full buffer can still take a capture when the oldest slot frees this cycle;
  // the write then lands in the slot being released (wr_ptr == rd_ptr when full).
  assign cap_accept   = strobe & ((count_q != 2'd2) | release_beat);
  assign cap_drop     = strobe & (count_q == 2'd2) & ~release_beat;

  always_comb begin
    count_d      = count_q + {1'b0, cap_accept} - {1'b0, release_beat};
    beat_d       = beat_q;
    query_addr_d = query_addr_q;
    overflow_d   = overflow_q;
    if (release_beat)  beat_d = '0;
    else if (xfer)     beat_d = beat_q + 1'b1;
    if (clear_addr)        query_addr_d = '0;
    else if (release_beat) query_addr_d = query_addr_q + 1'b1;
    // A same-cycle drop outranks clear_addr so the loss is never hidden.
    if (cap_drop)        overflow_d = 1'b1;
    else if (clear_addr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      beat_q       <= '0;
      query_addr_q <= '0;
      overflow_q   <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < NUM_PATCH; k++) begin
          idx_q[s][k]  <= '0;
          dist_q[s][k] <= '0;
        end
      end
    end else begin
      count_q      <= count_d;
      beat_q       <= beat_d;
      query_addr_q <= query_addr_d;
      overflow_q   <= overflow_d;
      if (release_beat) rd_ptr_q <= ~rd_ptr_q;
      if (cap_accept) begin
        wr_ptr_q <= ~wr_ptr_q;
        for (int k = 0; k < NUM_PATCH; k++) begin
          idx_q[wr_ptr_q][k]  <= in_idx[k*IDX_W +: IDX_W];
          dist_q[wr_ptr_q][k] <= in_dist[k*DIST_W +: DIST_W];
        end
      end
    end
  end

  assign rd_idx    = idx_q[rd_ptr_q][beat_q];
  assign rd_dist   = dist_q[rd_ptr_q][beat_q];
  assign out_valid = (count_q != 2'd0);
  assign busy      = (count_q != 2'd0);
  assign overflow  = overflow_q;
  assign out_dist  = rd_dist;
  assign out_addr  = {query_addr_q, beat_q};

`ifdef RESULT_THRESH_EN
  assign out_idx = (rd_dist > dist_thresh) ? {IDX_W{1'b1}} : rd_idx;
`else
  assign out_idx = rd_idx;
`endif

endmodule

// File: tb/tb_kd_result_serializer.sv
// Directed testbench for kd_result_serializer (ADDR_W=2 to exercise wrap).
module tb_kd_result_serializer;
  localparam int NP = 8;
  localparam int IW = 15;
  localparam int DW = 11;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_last, clear_addr, out_ready;
  logic [NP*IW-1:0]  in_idx;
  logic [NP*DW-1:0]  in_dist;
  logic              out_valid, busy, overflow;
  logic [IW-1:0]     out_idx;
  logic [DW-1:0]     out_dist;
  logic [AW+2:0]     out_addr;
`ifdef RESULT_THRESH_EN
  logic [DW-1:0]     dist_thresh = '1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  kd_result_serializer #(.NUM_PATCH(NP), .IDX_W(IW), .DIST_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_idx(in_idx), .in_dist(in_dist), .clear_addr(clear_addr),
`ifdef RESULT_THRESH_EN
    .dist_thresh(dist_thresh),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_dist(out_dist), .out_addr(out_addr), .busy(busy), .overflow(overflow)
  );

  task automatic load_query(input logic [IW-1:0] base, input logic [DW-1:0] step);
    for (int k = 0; k < NP; k++) begin
      in_idx[k*IW +: IW]  = base + IW'(k);
      in_dist[k*DW +: DW] = step * DW'(k);
    end
  endtask

  // One-cycle capture strobe, optionally together with clear_addr.
  task automatic strobe(input logic [IW-1:0] base, input logic [DW-1:0] step, input logic clr);
    load_query(base, step);
    in_valid = 1'b1; in_last = 1'b1; clear_addr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clear_addr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 0; in_last = 0; clear_addr = 0; out_ready = 0;
    in_idx = '0; in_dist = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_tests++; if (out_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", out_addr); end
    n_tests++; if (out_idx !== 15'd0) begin n_fail++; $display("FAIL reset_idx got %h want 0", out_idx); end
    n_tests++; if (out_dist !== 11'd0) begin n_fail++; $display("FAIL reset_dist got %h want 0", out_dist); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_query(15'h7000, 11'd1);
    in_valid = 1'b1; @(posedge clk); #1; in_valid = 1'b0;
    in_last = 1'b1;  @(posedge clk); #1; in_last = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_partial_busy got %b want 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_partial_valid got %b want 0", out_valid); end
    $display("[TB] reset and partial strobes done");
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    strobe(15'h100, 11'd10, 1'b0);
    for (int b = 0; b < NP; b++) begin
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid beat %0d got %b want 1", b, out_valid); end
      n_tests++; if (out_idx !== 15'h100 + 15'(b)) begin n_fail++; $display("FAIL single_idx beat %0d got %h want %h", b, out_idx, 15'h100 + 15'(b)); end
      n_tests++; if (out_dist !== 11'(10*b)) begin n_fail++; $display("FAIL single_dist beat %0d got %0d want %0d", b, out_dist, 10*b); end
      n_tests++; if (out_addr !== 5'(b)) begin n_fail++; $display("FAIL single_addr beat %0d got %h want %h", b, out_addr, b); end
      @(posedge clk); #1;
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
    n_tests++; if (out_addr !== 5'd8) begin n_fail++; $display("FAIL single_qaddr got %h want 08", out_addr); end
    $display("[TB] single query drained");
  endtask

  task automatic test_backpressure;
    int n = 0;
    int c = 0;
    out_ready = 1'b0;
    strobe(15'h200, 11'd3, 1'b0);
    while (n < NP && c < 40) begin
      out_ready = (c % 3 == 0);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want 1", c, out_valid); end
      n_tests++; if (out_idx !== 15'h200 + 15'(n)) begin n_fail++; $display("FAIL bp_idx cyc %0d got %h want %h", c, out_idx, 15'h200 + 15'(n)); end
      n_tests++; if (out_dist !== 11'(3*n)) begin n_fail++; $display("FAIL bp_dist cyc %0d got %0d want %0d", c, out_dist, 3*n); end
      n_tests++; if (out_addr !== {2'd1, 3'(n)}) begin n_fail++; $display("FAIL bp_addr cyc %0d got %h want %h", c, out_addr, {2'd1, 3'(n)}); end
      @(posedge clk); #1;
      if (out_ready) n++;
      c++;
    end
    out_ready = 1'b0;
    n_tests++; if (n !== NP) begin n_fail++; $display("FAIL bp_timeout transfers %0d want %0d", n, NP); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got %b want 0", busy); end
    $display("[TB] backpressure drain done");
  endtask

  task automatic test_overflow;
    logic [IW-1:0] base;
    logic [DW-1:0] step;
    out_ready = 1'b0;
    strobe(15'h300, 11'd5, 1'b0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
    strobe(15'h400, 11'd7, 1'b0);
    strobe(15'h500, 11'd9, 1'b0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int b = 0; b < 2*NP; b++) begin
      base = (b < NP) ? 15'h300 : 15'h400;
      step = (b < NP) ? 11'd5 : 11'd7;
      n_tests++; if (out_idx !== base + 15'(b % NP)) begin n_fail++; $display("FAIL ovf_idx beat %0d got %h want %h", b, out_idx, base + 15'(b % NP)); end
      n_tests++; if (out_dist !== step * 11'(b % NP)) begin n_fail++; $display("FAIL ovf_dist beat %0d got %0d want %0d", b, out_dist, step * 11'(b % NP)); end
      n_tests++; if (out_addr !== {(b < NP) ? 2'd2 : 2'd3, 3'(b % NP)}) begin n_fail++; $display("FAIL ovf_addr beat %0d got %h", b, out_addr); end
      @(posedge clk); #1;
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_end got %b want 0 (dropped query drained)", busy); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_tests++; if (out_addr !== 5'd0) begin n_fail++; $display("FAIL addr_wrap got %h want 00", out_addr); end
    clear_addr = 1'b1; @(posedge clk); #1; clear_addr = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    $display("[TB] overflow and wrap done");
  endtask

  task automatic test_simul;
    out_ready = 1'b0;
    strobe(15'h600, 11'd2, 1'b0);
    strobe(15'h700, 11'd4, 1'b0);
    strobe(15'h5AA, 11'd1, 1'b1);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear got %b want 1", overflow); end
    clear_addr = 1'b1; @(posedge clk); #1; clear_addr = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_preclear got %b want 0", overflow); end
    out_ready = 1'b1;
    for (int b = 0; b < NP-1; b++) begin
      n_tests++; if (out_idx !== 15'h600 + 15'(b)) begin n_fail++; $display("FAIL simul_a_idx beat %0d got %h want %h", b, out_idx, 15'h600 + 15'(b)); end
      @(posedge clk); #1;
    end
    n_tests++; if (out_addr !== 5'd7) begin n_fail++; $display("FAIL simul_a_last_addr got %h want 07", out_addr); end
    strobe(15'h080, 11'd6, 1'b0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf got %b want 0", overflow); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy got %b want 1", busy); end
    for (int b = 0; b < 2*NP; b++) begin
      n_tests++; if (out_idx !== ((b < NP) ? 15'h700 : 15'h080) + 15'(b % NP)) begin n_fail++; $display("FAIL simul_idx beat %0d got %h", b, out_idx); end
      n_tests++; if (out_dist !== ((b < NP) ? 11'd4 : 11'd6) * 11'(b % NP)) begin n_fail++; $display("FAIL simul_dist beat %0d got %0d", b, out_dist); end
      n_tests++; if (out_addr !== {(b < NP) ? 2'd1 : 2'd2, 3'(b % NP)}) begin n_fail++; $display("FAIL simul_addr beat %0d got %h", b, out_addr); end
      @(posedge clk); #1;
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy_end got %b want 0", busy); end
    n_tests++; if (out_addr !== 5'd24) begin n_fail++; $display("FAIL simul_qaddr got %h want 18", out_addr); end
    $display("[TB] simultaneous release/capture done");
  endtask

  task automatic test_clear_release;
    out_ready = 1'b1;
    strobe(15'h010, 11'd1, 1'b0);
    for (int b = 0; b < NP-1; b++) begin
      n_tests++; if (out_addr !== {2'd3, 3'(b)}) begin n_fail++; $display("FAIL clr_d_addr beat %0d got %h", b, out_addr); end
      @(posedge clk); #1;
    end
    clear_addr = 1'b1; @(posedge clk); #1; clear_addr = 1'b0;
    n_tests++; if (out_addr !== 5'd0) begin n_fail++; $display("FAIL clr_release_addr got %h want 00", out_addr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_release_busy got %b want 0", busy); end
    strobe(15'h020, 11'd2, 1'b0);
    for (int b = 0; b < NP; b++) begin
      n_tests++; if (out_idx !== 15'h020 + 15'(b)) begin n_fail++; $display("FAIL clr_e_idx beat %0d got %h", b, out_idx); end
      n_tests++; if (out_addr !== {2'd0, 3'(b)}) begin n_fail++; $display("FAIL clr_e_addr beat %0d got %h", b, out_addr); end
      @(posedge clk); #1;
    end
    n_tests++; if (out_addr !== 5'd8) begin n_fail++; $display("FAIL clr_e_qaddr got %h want 08", out_addr); end
    $display("[TB] clear on release done");
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    strobe(15'h030, 11'd3, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    n_tests++; if (out_idx !== 15'h033) begin n_fail++; $display("FAIL mid_beat3_idx got %h want 0033", out_idx); end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_tests++; if (out_addr !== 5'd0) begin n_fail++; $display("FAIL mid_rst_addr got %h want 00", out_addr); end
    n_tests++; if (out_idx !== 15'd0) begin n_fail++; $display("FAIL mid_rst_idx got %h want 0", out_idx); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid got %b want 0", out_valid); end
    $display("[TB] reset mid-drain done");
  endtask

`ifdef RESULT_THRESH_EN
  task automatic test_thresh;
    dist_thresh = 11'd25;
    out_ready = 1'b1;
    strobe(15'h100, 11'd10, 1'b0);
    for (int b = 0; b < NP; b++) begin
      n_tests++; if (out_idx !== ((10*b > 25) ? 15'h7FFF : 15'h100 + 15'(b))) begin n_fail++; $display("FAIL thresh_idx beat %0d got %h", b, out_idx); end
      n_tests++; if (out_dist !== 11'(10*b)) begin n_fail++; $display("FAIL thresh_dist beat %0d got %0d want %0d", b, out_dist, 10*b); end
      @(posedge clk); #1;
    end
    dist_thresh = '1;
    $display("[TB] threshold marker done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simul();
    test_clear_release();
    test_reset_mid();
`ifdef RESULT_THRESH_EN
    test_thresh();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kd_result_serializer.md
Name: kd_result_serializer

Overview:
- Sits directly downstream of the per-query running-minimum stage.
- At each query end, captures the final 8 per-patch {index, L2 distance} minima into a 2-slot ping-pong buffer.
- Drains them one patch per beat over a valid/ready stream to the result-memory writer, with a generated write address.
- Capture of query N+1 may overlap the draining of query N.

Parameters:
- NUM_PATCH, 8, patches per query (power of two, ≥2)
- IDX_W, 15, width of a {leaf, point} match index
- DIST_W, 11, width of an L2 distance
- ADDR_W, 9, width of the query address counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream valid (running-min valid_out)
- in_last  in  1  upstream query-last flag; capture strobe = in_valid & in_last
- in_idx  in  NUM_PATCH*IDX_W  flat per-patch min index; patch k at bits [k*IDX_W +: IDX_W]
- in_dist  in  NUM_PATCH*DIST_W  flat per-patch min distance; same packing
- clear_addr  in  1  frame start: zero query address and overflow flag
- out_valid  out  1  result beat available
- out_ready  in  1  downstream accepts beat
- out_idx  out  IDX_W  index of current beat
- out_dist  out  DIST_W  distance of current beat
- out_addr  out  ADDR_W+log2(NUM_PATCH)  {query_addr, beat}
- busy  out  1  count != 0
- overflow  out  1  sticky: a capture was dropped

Behaviour:
- State:
  - two slots of NUM_PATCH entries
  - wr_ptr, rd_ptr (1 bit each)
  - count (0..2)
  - beat (log2 NUM_PATCH bits)
  - query_addr (ADDR_W bits)
  - overflow
- Reset:
  - all state 0; slot contents 0
  - out_valid=0, busy=0, overflow=0, out_addr=0
  - out_idx=0, out_dist=0
- Transfer: out_valid & out_ready.
- Release: a transfer with beat==NUM_PATCH-1.
- Capture strobe, accepted if count<2, or count==2 with a release in the same cycle:
  - write all NUM_PATCH entries into slot[wr_ptr] at the clock edge
  - toggle wr_ptr
- Capture strobe with count==2 and no release: data dropped, overflow<=1 next cycle, no other state change.
- count update: +1 on accepted capture, -1 on release, unchanged when both occur.
- Output timing:
  - out_valid = (count!=0), registered state only
  - out_idx and out_dist = slot[rd_ptr][beat], combinational read of registers, no added latency
  - a capture into an empty buffer gives out_valid=1 on the cycle after the strobe
- On transfer: beat+1.
- On release:
  - beat<=0, toggle rd_ptr
  - query_addr+1, wrapping 2^ADDR_W-1 -> 0
- out_valid held, and out_idx/out_dist/out_addr stable, while out_ready=0 (AXI-stream rule).
- clear_addr:
  - query_addr<=0, overflow<=0
  - takes priority over a same-cycle release increment
  - does not flush buffered slots or reset beat
  - overflow-set and clear_addr in the same cycle: overflow ends 1 (set wins)
- in_valid without in_last: ignored.
- in_last without in_valid: ignored.
- Mid-operation async reset: all state cleared immediately; buffered results are lost.
- Throughput: one beat/cycle sustained. With out_ready held 1, queries of ≥NUM_PATCH cycles never overflow.

Optional Feature:
- Macro: RESULT_THRESH_EN.
- When defined:
  - adds input dist_thresh [DIST_W]
  - on a beat with out_dist > dist_thresh, out_idx is forced to all-ones (no-match marker)
  - out_dist is passed unchanged; comparison is unsigned, combinational, sampled every beat
- When undefined: port absent; out_idx always equals the stored index.

Test Plan:
- Single capture, idle sink:
  - patch k idx=0x100+k, dist=10*k; out_ready=1
  - -> 8 consecutive beats next cycle onward, idx 0x100..0x107, dist 0,10..70, out_addr 0..7
  - -> busy falls after beat 7; query_addr=1
- Backpressure:
  - out_ready toggles 1,0,0,1... during drain
  - -> out_* stable while stalled; exactly 8 transfers, order preserved
- Overlap and overflow:
  - out_ready=0, three strobes
  - -> count=2, third strobe dropped, overflow=1
  - then out_ready=1 -> 16 beats from first two queries only
- Simultaneous release and capture at count==2:
  - -> capture accepted, count stays 2, overflow=0
- Address wrap and clear:
  - ADDR_W=2, 5 queries -> out_addr query field 0,1,2,3,0
  - clear_addr on a release cycle -> next query field 0
- Reset mid-drain:
  - rst_n low at beat 3 -> out_valid=0, count=0, out_addr=0 immediately
  - with RESULT_THRESH_EN, dist_thresh=25: beats with dist 30..70 show out_idx=0x7FFF
